booth_product_accum: RTL and testbench
======================================

Name: booth_product_accum

Overview:
Multiply-accumulate back end that sits directly downstream of the radix-4 Booth multiplier. It takes one signed product per handshake and sums a frame of LEN products into a guarded accumulator. Each completed frame total is presented on a valid/ready output port. While a result waits for the consumer, the block stalls the multiplier side.

Parameters:
ARG_WIDTH, 16, multiplier operand width; product width is 2*ARG_WIDTH
GUARD_BITS, 8, extra accumulator MSBs; ACC_WIDTH = 2*ARG_WIDTH + GUARD_BITS
LEN_WIDTH, 8, width of the frame-length input and the count output
SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active-high
len  in  LEN_WIDTH  frame length; sampled on the first accepted product of each frame; 0 is treated as 1
prod_valid  in  1  product is valid
prod_ready  out  1  block can accept a product
product  in  2*ARG_WIDTH  signed product from the multiplier
clear  in  1  synchronous abort of the current frame or pending result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_acc  out  ACC_WIDTH  signed frame sum
out_overflow  out  1  overflow occurred in this frame (sticky per frame)
out_count  out  LEN_WIDTH  number of products summed (equals the effective len)

Behaviour:
- Reset (highest priority): state=ACCUM, acc=0, count=0, len_q=0, ovf=0, out_valid=0, out_acc=0, out_overflow=0, out_count=0. prod_ready=1 on the first cycle after reset is released.
- States: ACCUM and DONE. prod_ready = (state==ACCUM) and not clear; it is combinational from state and clear.
- Accept = prod_valid and prod_ready.
- ACCUM, accept with count==0:
  - acc <= sign-extended product.
  - len_q <= (len==0 ? 1 : len).
  - count <= 1; ovf <= 0.
- ACCUM, accept with count>0: acc <= acc + sign-extended product; count <= count+1.
- Overflow on an add is detected from the sign bits: both operands have the same sign and the sum sign differs.
  - SATURATE=1: acc <= +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), following the operand sign; ovf <= 1.
  - SATURATE=0: the sum wraps; ovf <= 1.
  - ovf stays set until the frame ends.
- Frame end: when an accept makes count equal len_q (using the new len_q for the first product):
  - Next cycle: state=DONE, out_valid=1, out_acc=final acc, out_overflow=ovf, out_count=len_q.
  - Internal count resets to 0.
  - Latency is 1 cycle from the last accepted product to out_valid.
- DONE:
  - prod_ready=0.
  - out_acc, out_overflow and out_count are held stable while out_valid=1 and out_ready=0.
  - out_valid and out_ready both high: next cycle out_valid=0 and state=ACCUM. A new frame can be accepted from that cycle onward; there is no same-cycle overlap.
- clear (below reset, above everything else):
  - Next cycle: state=ACCUM, count=0, acc=0, ovf=0, out_valid=0.
  - A pending result is dropped.
  - A product presented in the clear cycle is not accepted, because prod_ready is low.
  - out_acc, out_overflow and out_count keep their last values; they are don't-care while out_valid=0.
- prod_valid asserted in DONE: ignored and not accepted. The upstream source must hold the product until prod_ready is high.
- len changes mid-frame: ignored; only len_q is used.
- len == 2^LEN_WIDTH-1: the frame completes at count=255, and count never wraps.
- out_valid must not deassert without a handshake, clear, or reset.

Test Plan:
- Basic frame, len=4, products 3, -5, 100, 7 back-to-back -> one cycle after the 4th accept: out_valid=1, out_acc=105, out_count=4, out_overflow=0. prod_ready=0 until out_ready.
- Back-pressure: complete a len=2 frame (products 1000, -1) and hold out_ready=0 for 10 cycles while prod_valid=1 -> out_acc=999 stable; prod_ready=0 and no product consumed. Then pulse out_ready -> out_valid drops next cycle and the next product is accepted as count 1.
- Length zero: len=0 with a single product -12345 -> frame completes after 1 product, out_acc=-12345, out_count=1.
- Saturation, GUARD_BITS=4 (ACC_WIDTH=36), SATURATE=1, len=40, every product 2^30 (-32768 * -32768) -> out_acc = 2^35-1 = 34359738367, out_overflow=1. Repeat with SATURATE=0 -> wrapped value -2^35 + 8*2^30 = -25769803776, out_overflow=1.
- Clear mid-frame: len=5, accept 3 products of 50, assert clear for 1 cycle, then send 5 products of 2 -> exactly one result, out_acc=10, out_count=5. Clear asserted in DONE drops the pending result (out_valid goes low next cycle).
- Reset mid-frame with prod_valid held high -> prod_ready=1 on the first cycle after reset; out_valid=0; the next frame sums only post-reset products.

Source files
------------

// File: rtl/booth_product_accum.sv
// Frame accumulator behind the radix-4 Booth multiplier: sums len signed products into a
// guarded accumulator and presents each frame total on a valid/ready port.
module booth_product_accum #(
   parameter int unsigned ARG_WIDTH  = 16,
   parameter int unsigned GUARD_BITS = 8,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [LEN_WIDTH-1:0]              len,
   input  logic                              prod_valid,
   output logic                              prod_ready,
   input  logic [2*ARG_WIDTH-1:0]            product,
   input  logic                              clear,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [2*ARG_WIDTH+GUARD_BITS-1:0] out_acc,
   output logic                              out_overflow,
   output logic [LEN_WIDTH-1:0]              out_count
);

   localparam int unsigned PROD_WIDTH = 2 * ARG_WIDTH;
   localparam int unsigned ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [0:0] {StAccum, StDone} state_e;

   state_e state_q, state_d;

   logic [ACC_WIDTH-1:0] acc_q;
   logic [LEN_WIDTH-1:0] count_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic                 ovf_q;
   logic [ACC_WIDTH-1:0] out_acc_q;
   logic                 out_overflow_q;
   logic [LEN_WIDTH-1:0] out_count_q;

   logic                 accept;
   logic                 first;
   logic [LEN_WIDTH-1:0] len_eff;
   logic [LEN_WIDTH-1:0] len_target;
   logic [LEN_WIDTH-1:0] count_new;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH-1:0] acc_base;
   logic [ACC_WIDTH-1:0] acc_sum;
   logic [ACC_WIDTH-1:0] acc_new;
   logic                 ovf_add;
   logic                 ovf_new;
   logic                 frame_end;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StAccum;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = StAccum;
      end else begin
         unique case (state_q)
            StAccum: if (frame_end) state_d = StDone;
            StDone:  if (out_ready) state_d = StAccum;
            default: state_d = StAccum;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      prod_ready = (state_q == StAccum) && !clear;
      out_valid  = (state_q == StDone);
   end

   // ---------------- Datapath ----------------
   always_comb begin
      accept     = prod_valid && prod_ready;
      first      = (count_q == '0);
      len_eff    = (len == '0) ? LEN_WIDTH'(1) : len;
      len_target = first ? len_eff : len_q;
      count_new  = count_q + LEN_WIDTH'(1);
      prod_ext   = ACC_WIDTH'($signed(product));
      // The first product of a frame loads rather than adds, so it can never overflow.
      acc_base   = first ? '0 : acc_q;
      acc_sum    = acc_base + prod_ext;
      ovf_add    = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
      acc_new    = acc_sum;
      if (ovf_add && SATURATE) begin
         acc_new = acc_base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
      ovf_new    = (first ? 1'b0 : ovf_q) | ovf_add;
      frame_end  = accept && (count_new == len_target);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q          <= '0;
         count_q        <= '0;
         len_q          <= '0;
         ovf_q          <= 1'b0;
         out_acc_q      <= '0;
         out_overflow_q <= 1'b0;
         out_count_q    <= '0;
      end else if (clear) begin
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         acc_q <= acc_new;
         ovf_q <= ovf_new;
         if (first) begin
            len_q <= len_eff;
         end
         if (frame_end) begin
            count_q        <= '0;
            out_acc_q      <= acc_new;
            out_overflow_q <= ovf_new;
            out_count_q    <= len_target;
         end else begin
            count_q <= count_new;
         end
      end
   end

   assign out_acc      = out_acc_q;
   assign out_overflow = out_overflow_q;
   assign out_count    = out_count_q;

endmodule

// File: tb/tb_booth_product_accum.sv
// Bench for booth_product_accum: three instances (ACC 40/sat, 36/sat, 36/wrap) share stimulus
// and are compared each cycle against a transaction-level arithmetic model.
module tb_booth_product_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        prod_valid;
   logic        clear;
   logic        out_ready;
   logic [7:0]  len;
   logic [31:0] product;

   logic        ready0, ready1, ready2;
   logic        valid0, valid1, valid2;
   logic [39:0] acc0;
   logic [35:0] acc1, acc2;
   logic        ovf0, ovf1, ovf2;
   logic [7:0]  cnt0, cnt1, cnt2;

   booth_product_accum #(
      .ARG_WIDTH(16), .GUARD_BITS(8), .LEN_WIDTH(8), .SATURATE(1'b1)
   ) u_dut0 (
      .clk(clk), .reset(reset), .len(len), .prod_valid(prod_valid), .prod_ready(ready0),
      .product(product), .clear(clear), .out_valid(valid0), .out_ready(out_ready),
      .out_acc(acc0), .out_overflow(ovf0), .out_count(cnt0)
   );

   booth_product_accum #(
      .ARG_WIDTH(16), .GUARD_BITS(4), .LEN_WIDTH(8), .SATURATE(1'b1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .len(len), .prod_valid(prod_valid), .prod_ready(ready1),
      .product(product), .clear(clear), .out_valid(valid1), .out_ready(out_ready),
      .out_acc(acc1), .out_overflow(ovf1), .out_count(cnt1)
   );

   booth_product_accum #(
      .ARG_WIDTH(16), .GUARD_BITS(4), .LEN_WIDTH(8), .SATURATE(1'b0)
   ) u_dut2 (
      .clk(clk), .reset(reset), .len(len), .prod_valid(prod_valid), .prod_ready(ready2),
      .product(product), .clear(clear), .out_valid(valid2), .out_ready(out_ready),
      .out_acc(acc2), .out_overflow(ovf2), .out_count(cnt2)
   );

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Reference model state
   bit     m_valid;
   int     m_count;
   int     m_len;
   longint m_acc [3];
   bit     m_ovf [3];
   longint e_acc [3];
   bit     e_ovf [3];
   int     e_cnt;
   bit     accepted;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void madd(input int k, input longint p);
      int     w;
      bit     sat;
      longint mx, mn, s;
      w   = (k == 0) ? 40 : 36;
      sat = (k != 2);
      mx  = (longint'(1) <<< (w - 1)) - 1;
      mn  = -(longint'(1) <<< (w - 1));
      s   = m_acc[k] + p;
      if (s > mx) begin
         m_ovf[k] = 1'b1;
         s = sat ? mx : s - (mx - mn + 1);
      end else if (s < mn) begin
         m_ovf[k] = 1'b1;
         s = sat ? mn : s + (mx - mn + 1);
      end
      m_acc[k] = s;
   endfunction

   task automatic model_edge();
      longint p;
      accepted = 1'b0;
      p = longint'($signed(product));
      if (reset || clear) begin
         m_valid = 1'b0;
         m_count = 0;
      end else if (!m_valid) begin
         if (prod_valid) begin
            accepted = 1'b1;
            if (m_count == 0) begin
               m_len = (len == 8'd0) ? 1 : int'(len);
               for (int k = 0; k < 3; k++) begin
                  m_acc[k] = p;
                  m_ovf[k] = 1'b0;
               end
            end else begin
               for (int k = 0; k < 3; k++) madd(k, p);
            end
            m_count++;
            if (m_count == m_len) begin
               m_valid = 1'b1;
               m_count = 0;
               e_cnt   = m_len;
               for (int k = 0; k < 3; k++) begin
                  e_acc[k] = m_acc[k];
                  e_ovf[k] = m_ovf[k];
               end
            end
         end
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Inputs are set just after a falling edge; one call covers one rising edge.
   task automatic step();
      #1;
      if (!reset) begin
         check("prod_ready0", ready0, !m_valid && !clear);
         check("prod_ready1", ready1, !m_valid && !clear);
         check("prod_ready2", ready2, !m_valid && !clear);
      end
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check("out_valid0", valid0, m_valid);
      check("out_valid1", valid1, m_valid);
      check("out_valid2", valid2, m_valid);
      if (m_valid) begin
         check("out_acc0", $signed(acc0), e_acc[0]);
         check("out_acc1", $signed(acc1), e_acc[1]);
         check("out_acc2", $signed(acc2), e_acc[2]);
         check("out_ovf0", ovf0, e_ovf[0]);
         check("out_ovf1", ovf1, e_ovf[1]);
         check("out_ovf2", ovf2, e_ovf[2]);
         check("out_count0", cnt0, e_cnt);
         check("out_count1", cnt1, e_cnt);
         check("out_count2", cnt2, e_cnt);
      end
   endtask

   task automatic push(input logic [31:0] p);
      prod_valid = 1'b1;
      product    = p;
      accepted   = 1'b0;
      for (int i = 0; i < 64 && !accepted; i++) step();
      if (!accepted) begin
         $display("FAIL push_timeout observed=not_accepted expected=accepted");
         $fatal(1, "push timeout");
      end
   endtask

   task automatic take(input int delay);
      prod_valid = 1'b0;
      out_ready  = 1'b0;
      for (int i = 0; i < delay; i++) step();
      out_ready = 1'b1;
      for (int i = 0; i < 4 && m_valid; i++) step();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; prod_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
      len = 8'd4; product = '0;
      m_valid = 1'b0; m_count = 0; m_len = 1; e_cnt = 0;
      step();
      step();
      check("reset_acc", $signed(acc0), 0);
      check("reset_count", cnt0, 0);
      check("reset_ovf", ovf0, 0);
      reset = 1'b0;

      // Basic frame
      len = 8'd4;
      push(32'd3); push(-32'sd5); push(32'd100); push(32'd7);
      prod_valid = 1'b0;
      check("basic_acc", $signed(acc0), 105);
      check("basic_count", cnt0, 4);
      check("basic_ovf", ovf0, 0);
      take(2);

      // Back-pressure with a product waiting upstream
      len = 8'd2;
      push(32'd1000); push(-32'sd1);
      prod_valid = 1'b1; product = 32'd77;
      for (int i = 0; i < 10; i++) step();
      check("bp_acc_held", $signed(acc0), 999);
      check("bp_ready_low", ready0, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_valid_drop", valid0, 0);
      step();
      check("bp_first_accept", accepted, 1);
      push(32'd3);
      prod_valid = 1'b0;
      check("bp_second_acc", $signed(acc0), 80);
      take(0);

      // Length zero behaves as one
      len = 8'd0;
      push(-32'sd12345);
      prod_valid = 1'b0;
      check("len0_acc", $signed(acc0), -12345);
      check("len0_count", cnt0, 1);
      take(1);

      // Saturation / wrap
      len = 8'd40;
      for (int i = 0; i < 40; i++) push(32'h4000_0000);
      prod_valid = 1'b0;
      check("sat_acc36", $signed(acc1), 64'sd34359738367);
      check("sat_ovf36", ovf1, 1);
      check("wrap_acc36", $signed(acc2), -64'sd25769803776);
      check("wrap_ovf36", ovf2, 1);
      check("nosat_acc40", $signed(acc0), 64'sd42949672960);
      check("nosat_ovf40", ovf0, 0);
      take(0);

      // Clear mid-frame, then clear in DONE
      len = 8'd5;
      push(32'd50); push(32'd50); push(32'd50);
      prod_valid = 1'b1; product = 32'd50; clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 5; i++) push(32'd2);
      prod_valid = 1'b0;
      check("clr_acc", $signed(acc0), 10);
      check("clr_count", cnt0, 5);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_done_drop", valid0, 0);
      step();

      // Reset mid-frame with prod_valid held
      len = 8'd6;
      push(32'd1000); push(32'd1000); push(32'd1000);
      prod_valid = 1'b1; product = 32'd9; reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_valid", valid0, 0);
      step();
      check("rst_accept", accepted, 1);
      for (int i = 0; i < 5; i++) push(32'd1);
      prod_valid = 1'b0;
      check("rst_acc", $signed(acc0), 14);
      take(0);

      // Longest frame; count must not wrap
      len = 8'd255;
      for (int i = 0; i < 255; i++) push(32'h8000_0000);
      prod_valid = 1'b0;
      check("len255_count", cnt0, 255);
      check("len255_ovf40", ovf0, 0);
      check("len255_sat36", $signed(acc1), -64'sd34359738368);
      take(1);

      // Randomized frames with gaps, mid-frame len changes and random consumer delay
      for (int f = 0; f < 12; f++) begin
         int n;
         len = 8'($urandom_range(0, 12));
         n   = (len == 8'd0) ? 1 : int'(len);
         for (int i = 0; i < n; i++) begin
            int r;
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
               prod_valid = 1'b0;
               step();
            end
            if (r == 0) push(32'h8000_0000);
            else if (r == 1) push(32'h7fff_ffff);
            else push($urandom);
            len = 8'($urandom_range(1, 255));
         end
         take($urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
